// File: rtl/apb_slv_regif.sv
// APB3/APB4 completer front-end: one APB transfer becomes a valid/ready request
// plus a response handshake. Optional request timeout: APB_SLV_REGIF_TIMEOUT_EN.
module apb_slv_regif #(
    parameter int ABITS          = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_psel,
    input  logic             i_penable,
    input  logic [31:0]      i_paddr,
    input  logic             i_pwrite,
    input  logic [31:0]      i_pwdata,
    input  logic [3:0]       i_pstrb,
    input  logic [2:0]       i_pprot,
    output logic             o_pready,
    output logic [31:0]      o_prdata,
    output logic             o_pslverr,
    output logic             o_req_valid,
    input  logic             i_req_ready,
    output logic [ABITS-1:0] o_req_addr,
    output logic             o_req_write,
    output logic [31:0]      o_req_wdata,
    output logic [3:0]       o_req_wstrb,
    output logic [2:0]       o_req_prot,
    input  logic             i_resp_valid,
    input  logic [31:0]      i_resp_rdata,
    input  logic             i_resp_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        WAITRESP = 2'd2,
        OUT      = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   setup;
    logic   busy;
    logic   timeout;
    logic   load_out;

    assign setup = i_psel & ~i_penable;
    assign busy  = (state_q == REQUEST) | (state_q == WAITRESP);

`ifdef APB_SLV_REGIF_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt_q <= '0;
        else if (state_q == IDLE && setup)
            cnt_q <= '0;
        else if (busy)
            cnt_q <= cnt_q + CW'(1);
    end

    assign timeout = busy & (cnt_q == CW'(TIMEOUT_CYCLES));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout        = 1'b0;
`endif

    logic unused_paddr;
    assign unused_paddr = ^i_paddr[31:ABITS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (setup) state_d = REQUEST;
            REQUEST:  if (timeout) state_d = OUT;
                      else if (i_req_ready) state_d = WAITRESP;
            WAITRESP: if (timeout | i_resp_valid) state_d = OUT;
            OUT:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign load_out    = busy & (state_d == OUT);
    assign o_req_valid = (state_q == REQUEST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_req_addr  <= '0;
            o_req_write <= 1'b0;
            o_req_wdata <= '0;
            o_req_wstrb <= '0;
            o_req_prot  <= '0;
        end else if (state_q == IDLE && setup) begin
            o_req_addr  <= i_paddr[ABITS-1:0];
            o_req_write <= i_pwrite;
            o_req_wdata <= i_pwdata;
            o_req_wstrb <= i_pwrite ? i_pstrb : 4'h0;
            o_req_prot  <= i_pprot;
        end
    end

    // A master that dropped psel before completion gets no pready at all.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pready  <= 1'b0;
            o_prdata  <= '0;
            o_pslverr <= 1'b0;
        end else if (load_out) begin
            o_pready  <= i_psel;
            o_prdata  <= (i_psel & ~timeout & ~o_req_write) ? i_resp_rdata : '0;
            o_pslverr <= i_psel & (timeout | i_resp_err);
        end else begin
            o_pready  <= 1'b0;
            o_prdata  <= '0;
            o_pslverr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_slv_regif.sv
// Self-checking bench for apb_slv_regif: directed test-plan cases plus random
// transfers against a cycle-count reference model of the APB/core handshake.
module tb_apb_slv_regif;

`ifdef APB_SLV_REGIF_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic        req_ready = 1'b0, resp_valid = 1'b0, resp_err = 1'b0;
    logic [31:0] resp_rdata = '0;
    logic        pready, pslverr, req_valid, req_write;
    logic [31:0] prdata, req_wdata;
    logic [11:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_prot;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_slv_regif #(.ABITS(12), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_psel(psel), .i_penable(penable), .i_paddr(paddr),
        .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
        .i_pprot(pprot),
        .o_pready(pready), .o_prdata(prdata), .o_pslverr(pslverr),
        .o_req_valid(req_valid), .i_req_ready(req_ready),
        .o_req_addr(req_addr), .o_req_write(req_write),
        .o_req_wdata(req_wdata), .o_req_wstrb(req_wstrb),
        .o_req_prot(req_prot),
        .i_resp_valid(resp_valid), .i_resp_rdata(resp_rdata),
        .i_resp_err(resp_err)
    );

    // Idle APB bus; core-side strobes are noise the design must ignore.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            psel = 0; penable = 0;
            req_ready = 1'($urandom_range(0, 1));
            resp_valid = 1'($urandom_range(0, 1));
            resp_rdata = $urandom;
            resp_err = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({pready, pslverr, req_valid} !== 3'b000 || prdata !== 0) begin
                errors++;
                $display("FAIL idle: pready=%b pslverr=%b req_valid=%b prdata=%h want 0",
                         pready, pslverr, req_valid, prdata);
            end
        end
    endtask

    // One APB transfer. Cycle 0 = setup; core takes rd cycles to accept,
    // then answers sd cycles into the wait phase.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p, input int rd,
                        input int sd, input logic [31:0] rdat, input logic e,
                        input string name);
        int          last = 3 + rd + sd;
        logic [31:0] exp_rd = w ? 32'h0 : rdat;
        logic [3:0]  exp_st = w ? s : 4'h0;
        logic        ev, ep;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            psel = 1;
            penable = (c != 0);
            if (c == 0) begin
                paddr = a; pwrite = w; pwdata = d; pstrb = s; pprot = p;
            end
            req_ready = (c == 1 + rd) ||
                        ((c == 0 || c > 1 + rd) && $urandom_range(0, 1) == 1);
            resp_valid = (c == 2 + rd + sd) ||
                         (c >= 1 && c <= 1 + rd && $urandom_range(0, 1) == 1);
            resp_rdata = (c == 2 + rd + sd) ? rdat : $urandom;
            resp_err = (c == 2 + rd + sd) ? e : 1'($urandom_range(0, 1));
            @(negedge clk);
            ev = (c >= 1 && c <= 1 + rd);
            ep = (c == last);
            checks++;
            if (req_valid !== ev || pready !== ep) begin
                errors++;
                $display("FAIL %s c%0d: req_valid=%b pready=%b want %b %b",
                         name, c, req_valid, pready, ev, ep);
            end
            checks++;
            if (prdata !== (ep ? exp_rd : 32'h0) || pslverr !== (ep & e)) begin
                errors++;
                $display("FAIL %s c%0d resp: prdata=%h pslverr=%b want %h %b",
                         name, c, prdata, pslverr, ep ? exp_rd : 32'h0, ep & e);
            end
            if (ev) begin
                checks++;
                if (req_addr !== a[11:0] || req_write !== w || req_wdata !== d ||
                    req_wstrb !== exp_st || req_prot !== p) begin
                    errors++;
                    $display("FAIL %s req: %h %b %h %h %h want %h %b %h %h %h",
                             name, req_addr, req_write, req_wdata, req_wstrb,
                             req_prot, a[11:0], w, d, exp_st, p);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({pready, pslverr, req_valid, req_write} !== 4'b0 || prdata !== 0 ||
            req_addr !== 0 || req_wdata !== 0 || req_wstrb !== 0 || req_prot !== 0) begin
            errors++;
            $display("FAIL %s: pready=%b pslverr=%b req_valid=%b prdata=%h addr=%h want all 0",
                     name, pready, pslverr, req_valid, prdata, req_addr);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 0;
        idle(2);
    endtask

    task automatic test_write_min;
        xfer(1, 32'h0000_0A14, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 0, 32'h5555_AAAA, 0,
             "write_min");
        idle(1);
    endtask

    task automatic test_read_delayed;
        xfer(0, 32'h0000_0100, 32'h0, 4'h0, 3'd2, 4, 2, 32'h1234_5678, 0,
             "read_delayed");
        idle(1);
    endtask

    task automatic test_read_err;
        xfer(0, 32'h0000_0FFC, 32'hCAFE_0000, 4'hA, 3'd1, 0, 1, 32'h0BAD_F00D, 1,
             "read_err");
        idle(1);
    endtask

    task automatic test_back_to_back;
        xfer(1, 32'h0000_0008, 32'h0102_0304, 4'h3, 3'd0, 0, 0, 32'h0, 0, "b2b_wr");
        xfer(0, 32'h0000_000C, 32'h0, 4'h0, 3'd0, 0, 0, 32'h8765_4321, 0, "b2b_rd");
        idle(1);
    endtask

    task automatic test_illegal_access;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            psel = 1; penable = 1; paddr = $urandom;
            req_ready = 1; resp_valid = 1;
            @(negedge clk);
            checks++;
            if (req_valid !== 1'b0 || pready !== 1'b0) begin
                errors++;
                $display("FAIL illegal: req_valid=%b pready=%b want 0 0",
                         req_valid, pready);
            end
        end
        idle(1);
    endtask

    task automatic test_abandon;
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = 32'h44;
        req_ready = 0; resp_valid = 0;
        @(posedge clk); #1;
        penable = 1; req_ready = 1;
        @(posedge clk); #1;
        psel = 0; penable = 0; req_ready = 0;
        resp_valid = 1; resp_rdata = 32'hFFFF_FFFF; resp_err = 1;
        idle(3);
        xfer(0, 32'h48, 32'h0, 4'h0, 3'd0, 1, 0, 32'h0000_0048, 0, "after_abandon");
        idle(1);
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h7F0;
        pwdata = 32'hA5A5_A5A5; pstrb = 4'hF; pprot = 3'd7;
        req_ready = 0; resp_valid = 0;
        @(posedge clk); #1;
        penable = 1; req_ready = 1;
        @(posedge clk); #1;
        req_ready = 0;
        #2 rst = 1;
        #1 check_all_zero("reset_mid");
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        resp_valid = 1; resp_rdata = 32'h1111_1111; resp_err = 1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            resp_valid = 0;
            @(negedge clk);
            checks++;
            if (pready !== 1'b0 || req_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_resp: pready=%b req_valid=%b want 0 0",
                         pready, req_valid);
            end
        end
        idle(1);
        xfer(0, 32'h7F0, 32'h0, 4'h0, 3'd0, 0, 0, 32'h2222_3333, 0, "after_reset");
        idle(1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom, 1'($urandom_range(0, 1)), "random");
            idle($urandom_range(0, 2));
        end
    endtask

`ifdef APB_SLV_REGIF_TIMEOUT_EN
    task automatic test_timeout;
        for (int c = 0; c <= 12; c++) begin
            @(posedge clk); #1;
            psel = (c <= 10);
            penable = (c >= 1 && c <= 10);
            if (c == 0) begin
                paddr = 32'h30; pwrite = 0; pstrb = 0; pprot = 0;
            end
            req_ready = 0;
            resp_valid = (c == 11);
            resp_rdata = 32'hFEED_FACE;
            resp_err = 0;
            @(negedge clk);
            checks++;
            if (req_valid !== (c >= 1 && c <= 9) || pready !== (c == 10) ||
                pslverr !== (c == 10) || prdata !== 32'h0) begin
                errors++;
                $display("FAIL timeout c%0d: req_valid=%b pready=%b pslverr=%b prdata=%h",
                         c, req_valid, pready, pslverr, prdata);
            end
        end
        idle(1);
    endtask
`endif

    initial begin
        test_reset;
        test_write_min;
        test_read_delayed;
        test_read_err;
        test_back_to_back;
        test_illegal_access;
        test_abandon;
        test_reset_mid;
        test_random;
`ifdef APB_SLV_REGIF_TIMEOUT_EN
        test_timeout;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
